// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode patterns, ALU op encodings,
// sequencer states and the instruction classes the sequencer acts on.
package legv8_pkg;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASS  = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE,
      C_LDUR,
      C_STUR,
      C_B,
      C_CBZ,
      C_ILL
   } opclass_t;

endpackage

// File: rtl/legv8_opclass.sv
// Combinational OPCODE (IR[31:21]) to instruction-class classifier.
module legv8_opclass
   import legv8_pkg::*;
(
   input  logic [10:0] opcode,
   output opclass_t    opclass
);

   always_comb begin
      opclass = C_ILL;
      if (opcode == OP_LDUR)
         opclass = C_LDUR;
      else if (opcode == OP_STUR)
         opclass = C_STUR;
      else if (opcode == OP_ADD || opcode == OP_SUB ||
               opcode == OP_AND || opcode == OP_ORR)
         opclass = C_RTYPE;
      else if (opcode[10:5] == OP_B_PFX)
         opclass = C_B;
      else if (opcode[10:3] == OP_CBZ_PFX)
         opclass = C_CBZ;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: walks each instruction through fetch, decode,
// execute, memory and write-back over one unified memory port.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_FETCH  | read instruction at PC; load IR/OLD_PC and PC+4 on ready
//   S_DECODE | classify opcode, latch class, flag illegal
//   S_EXEC   | ALU op; branches resolve and retire here
//   S_MEM    | data access at ALU result; STUR retires on ready
//   S_WB     | register file write from ALU or memory data
module multicycle_ctrl
   import legv8_pkg::*;
#(
   parameter int RETIRE_W = 32
)(
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic [10:0]         OPCODE,
   input  logic                ALU_ZERO,
   input  logic                MEM_READY,
   output logic                MEM_REQ,
   output logic                MEM_WE,
   output logic                IORD,
   output logic                IR_WRITE,
   output logic                PC_WRITE,
   output logic                PC_SRC,
   output logic                REG2LOC,
   output logic                ALUSRC,
   output logic [1:0]          ALU_OP,
   output logic                REGWRITE,
   output logic                MEM2REG,
   output logic                ILLEGAL,
   output logic [RETIRE_W-1:0] RETIRED
);

   state_t   state;
   opclass_t cls_q;
   opclass_t op_cls;
   opclass_t cls;
   logic     retire;

   legv8_opclass u_opclass (
      .opcode  (OPCODE),
      .opclass (op_cls)
   );

   // Decode sees the live opcode; later states use the latched class only.
   assign cls = (state == S_DECODE) ? op_cls : cls_q;

   assign retire = (state == S_WB) ||
                   (state == S_EXEC && (cls_q == C_B || cls_q == C_CBZ)) ||
                   (state == S_MEM && MEM_READY && cls_q == C_STUR);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state   <= S_FETCH;
         cls_q   <= C_ILL;
         RETIRED <= '0;
      end else begin
         if (retire)
            RETIRED <= RETIRED + RETIRE_W'(1);
         case (state)
            S_FETCH:  if (MEM_READY) state <= S_DECODE;
            S_DECODE: begin
               cls_q <= op_cls;
               state <= (op_cls == C_ILL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
               case (cls_q)
                  C_RTYPE:        state <= S_WB;
                  C_LDUR, C_STUR: state <= S_MEM;
                  default:        state <= S_FETCH;
               endcase
            end
            S_MEM:    if (MEM_READY) state <= (cls_q == C_LDUR) ? S_WB : S_FETCH;
            S_WB:     state <= S_FETCH;
            default:  state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      MEM_REQ  = 1'b0;
      MEM_WE   = 1'b0;
      IORD     = 1'b0;
      IR_WRITE = 1'b0;
      PC_WRITE = 1'b0;
      PC_SRC   = 1'b0;
      REG2LOC  = 1'b0;
      ALUSRC   = 1'b0;
      ALU_OP   = ALUOP_ADD;
      REGWRITE = 1'b0;
      MEM2REG  = 1'b0;
      ILLEGAL  = 1'b0;
      if (!RESET) begin
         case (state)
            S_FETCH: begin
               MEM_REQ  = 1'b1;
               IR_WRITE = MEM_READY;
               PC_WRITE = MEM_READY;
            end
            S_DECODE: begin
               REG2LOC = (cls == C_STUR || cls == C_CBZ);
               ILLEGAL = (cls == C_ILL);
            end
            S_EXEC: begin
               case (cls)
                  C_RTYPE: ALU_OP = ALUOP_FUNCT;
                  C_LDUR, C_STUR: ALUSRC = 1'b1;
                  C_CBZ: begin
                     ALU_OP   = ALUOP_PASS;
                     REG2LOC  = 1'b1;
                     PC_WRITE = ALU_ZERO;
                     PC_SRC   = ALU_ZERO;
                  end
                  C_B: begin
                     PC_WRITE = 1'b1;
                     PC_SRC   = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               MEM_REQ = 1'b1;
               IORD    = 1'b1;
               MEM_WE  = (cls == C_STUR);
            end
            S_WB: begin
               REGWRITE = 1'b1;
               MEM2REG  = (cls == C_LDUR);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; strobes packed into one word.
module tb_multicycle_ctrl;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [10:0] OPCODE;
   logic        ALU_ZERO;
   logic        MEM_READY;
   logic        MEM_REQ, MEM_WE, IORD, IR_WRITE, PC_WRITE, PC_SRC;
   logic        REG2LOC, ALUSRC, REGWRITE, MEM2REG, ILLEGAL;
   logic [1:0]  ALU_OP;
   logic [31:0] RETIRED;

   int n_checks = 0;
   int n_errors = 0;

   // {MEM_REQ,MEM_WE,IORD,IR_WRITE,PC_WRITE,PC_SRC,REG2LOC,ALUSRC,ALU_OP,REGWRITE,MEM2REG,ILLEGAL}
   localparam logic [12:0] V_ZERO   = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] V_F_WAIT = 13'b1_0_0_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] V_F_RDY  = 13'b1_0_0_1_1_0_0_0_00_0_0_0;
   localparam logic [12:0] V_D_R2L  = 13'b0_0_0_0_0_0_1_0_00_0_0_0;
   localparam logic [12:0] V_D_ILL  = 13'b0_0_0_0_0_0_0_0_00_0_0_1;
   localparam logic [12:0] V_X_R    = 13'b0_0_0_0_0_0_0_0_10_0_0_0;
   localparam logic [12:0] V_X_LS   = 13'b0_0_0_0_0_0_0_1_00_0_0_0;
   localparam logic [12:0] V_X_CBZT = 13'b0_0_0_0_1_1_1_0_01_0_0_0;
   localparam logic [12:0] V_X_CBZN = 13'b0_0_0_0_0_0_1_0_01_0_0_0;
   localparam logic [12:0] V_X_B    = 13'b0_0_0_0_1_1_0_0_00_0_0_0;
   localparam logic [12:0] V_M_LD   = 13'b1_0_1_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] V_M_ST   = 13'b1_1_1_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] V_W_R    = 13'b0_0_0_0_0_0_0_0_00_1_0_0;
   localparam logic [12:0] V_W_LD   = 13'b0_0_0_0_0_0_0_0_00_1_1_0;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_B    = 11'b00010111011;
   localparam logic [10:0] OP_ILL  = 11'b00000000000;

   multicycle_ctrl #(.RETIRE_W(32)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .OPCODE    (OPCODE),
      .ALU_ZERO  (ALU_ZERO),
      .MEM_READY (MEM_READY),
      .MEM_REQ   (MEM_REQ),
      .MEM_WE    (MEM_WE),
      .IORD      (IORD),
      .IR_WRITE  (IR_WRITE),
      .PC_WRITE  (PC_WRITE),
      .PC_SRC    (PC_SRC),
      .REG2LOC   (REG2LOC),
      .ALUSRC    (ALUSRC),
      .ALU_OP    (ALU_OP),
      .REGWRITE  (REGWRITE),
      .MEM2REG   (MEM2REG),
      .ILLEGAL   (ILLEGAL),
      .RETIRED   (RETIRED)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs, check the strobe word mid-cycle, advance one edge.
   task automatic cyc(input string tag, input logic [10:0] op, input logic rdy,
                      input logic z, input logic [12:0] exp);
      logic [12:0] outs;
      OPCODE    = op;
      MEM_READY = rdy;
      ALU_ZERO  = z;
      #2;
      outs = {MEM_REQ, MEM_WE, IORD, IR_WRITE, PC_WRITE, PC_SRC, REG2LOC,
              ALUSRC, ALU_OP, REGWRITE, MEM2REG, ILLEGAL};
      check(tag, 32'(outs), 32'(exp));
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      RESET     = 1'b1;
      OPCODE    = OP_ADD;
      MEM_READY = 1'b1;
      ALU_ZERO  = 1'b0;
      @(posedge CLOCK);
      #1;
      cyc("reset_outs0", OP_ADD, 1'b1, 1'b1, V_ZERO);
      cyc("reset_outs1", OP_ADD, 1'b1, 1'b1, V_ZERO);
      check("reset_retired", RETIRED, 32'd0);
      RESET = 1'b0;

      // ADD, zero-wait: 4 cycles
      cyc("add_fetch",  OP_ADD, 1'b1, 1'b0, V_F_RDY);
      cyc("add_decode", OP_ADD, 1'b1, 1'b0, V_ZERO);
      cyc("add_exec",   OP_ADD, 1'b1, 1'b0, V_X_R);
      check("add_pre_retire", RETIRED, 32'd0);
      cyc("add_wb",     OP_ADD, 1'b1, 1'b0, V_W_R);
      check("add_retired", RETIRED, 32'd1);

      // LDUR, two wait cycles in MEM; opcode changes after decode are ignored
      cyc("ld_fetch",  OP_LDUR, 1'b1, 1'b0, V_F_RDY);
      cyc("ld_decode", OP_LDUR, 1'b1, 1'b0, V_ZERO);
      cyc("ld_exec",   OP_ADD,  1'b1, 1'b0, V_X_LS);
      cyc("ld_mem_w0", OP_ILL,  1'b0, 1'b0, V_M_LD);
      cyc("ld_mem_w1", OP_STUR, 1'b0, 1'b0, V_M_LD);
      cyc("ld_mem_rdy", OP_ILL, 1'b1, 1'b0, V_M_LD);
      check("ld_no_early_retire", RETIRED, 32'd1);
      cyc("ld_wb",     OP_ILL,  1'b1, 1'b0, V_W_LD);
      check("ld_retired", RETIRED, 32'd2);

      // CBZ taken, then not taken
      cyc("cbz1_fetch",  OP_CBZ, 1'b1, 1'b1, V_F_RDY);
      cyc("cbz1_decode", OP_CBZ, 1'b1, 1'b1, V_D_R2L);
      cyc("cbz1_exec",   OP_CBZ, 1'b1, 1'b1, V_X_CBZT);
      check("cbz1_retired", RETIRED, 32'd3);
      cyc("cbz0_fetch",  OP_CBZ, 1'b1, 1'b0, V_F_RDY);
      cyc("cbz0_decode", OP_CBZ, 1'b1, 1'b0, V_D_R2L);
      cyc("cbz0_exec",   OP_CBZ, 1'b1, 1'b0, V_X_CBZN);
      check("cbz0_retired", RETIRED, 32'd4);

      // STUR with one fetch wait
      cyc("st_fetch_w", OP_STUR, 1'b0, 1'b0, V_F_WAIT);
      cyc("st_fetch",   OP_STUR, 1'b1, 1'b0, V_F_RDY);
      cyc("st_decode",  OP_STUR, 1'b1, 1'b0, V_D_R2L);
      cyc("st_exec",    OP_STUR, 1'b1, 1'b0, V_X_LS);
      cyc("st_mem",     OP_STUR, 1'b1, 1'b0, V_M_ST);
      check("st_retired", RETIRED, 32'd5);

      // B
      cyc("b_fetch",  OP_B, 1'b1, 1'b0, V_F_RDY);
      cyc("b_decode", OP_B, 1'b1, 1'b0, V_ZERO);
      cyc("b_exec",   OP_B, 1'b1, 1'b0, V_X_B);
      check("b_retired", RETIRED, 32'd6);

      // Illegal opcode: one-cycle pulse, back to FETCH, no retire
      cyc("ill_fetch",  OP_ILL, 1'b1, 1'b0, V_F_RDY);
      cyc("ill_decode", OP_ILL, 1'b1, 1'b0, V_D_ILL);
      cyc("ill_refetch", OP_ILL, 1'b0, 1'b0, V_F_WAIT);
      check("ill_retired", RETIRED, 32'd6);

      // SUB
      cyc("sub_fetch",  OP_SUB, 1'b1, 1'b0, V_F_RDY);
      cyc("sub_decode", OP_SUB, 1'b1, 1'b0, V_ZERO);
      cyc("sub_exec",   OP_SUB, 1'b1, 1'b0, V_X_R);
      cyc("sub_wb",     OP_SUB, 1'b1, 1'b0, V_W_R);
      check("sub_retired", RETIRED, 32'd7);

      // Reset in MEM with MEM_READY high aborts without retire
      cyc("rst_fetch",  OP_LDUR, 1'b1, 1'b0, V_F_RDY);
      cyc("rst_decode", OP_LDUR, 1'b1, 1'b0, V_ZERO);
      cyc("rst_exec",   OP_LDUR, 1'b1, 1'b0, V_X_LS);
      RESET = 1'b1;
      cyc("rst_in_mem", OP_LDUR, 1'b1, 1'b0, V_ZERO);
      check("rst_retired_clr", RETIRED, 32'd0);
      RESET = 1'b0;
      cyc("rst_first_cycle", OP_LDUR, 1'b0, 1'b0, V_F_WAIT);
      check("rst_no_retire", RETIRED, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
